// File: rtl/bcd_pkg.sv
// bcd_pkg: decimal constants and FSM state shared by the serial BCD adder and subtractor.
package bcd_pkg;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_ADJ = 4'd6;
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
endpackage

// File: rtl/bcd_digit_add.sv
// bcd_digit_add: combinational single-digit BCD add with decimal correction.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [4:0] w_t;
  assign w_t = {1'b0, a} + {1'b0, b} + {4'b0, ci};
  assign co  = w_t > {1'b0, BCD_MAX};
  assign s   = co ? w_t[3:0] + BCD_ADJ : w_t[3:0];
endmodule

// File: rtl/bcd_serial_adder.sv
// bcd_serial_adder: digit-serial packed-BCD adder, one digit per clock, LSD first.
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [4*NDIG-1:0] a,
  input  logic [4*NDIG-1:0] b,
  input  logic              cin,
  output logic              busy,
  output logic              done,
  output logic [4*NDIG-1:0] sum,
  output logic              cout,
  output logic              err
);
  localparam int CW = $clog2(NDIG + 1);
  state_t            r_state;
  logic [4*NDIG-1:0] r_a, r_b, r_sum;
  logic [CW-1:0]     r_cnt;
  logic              r_carry, r_cout, r_err;
  logic [NDIG-1:0]   w_bad;
  logic [3:0]        w_s;
  logic              w_co;
  logic [4*NDIG-1:0] w_sum_nx;
  for (genvar i = 0; i < NDIG; i++) begin : g_chk
    assign w_bad[i] = (a[4*i+:4] > BCD_MAX) | (b[4*i+:4] > BCD_MAX);
  end
  bcd_digit_add u_dig (.a(r_a[3:0]), .b(r_b[3:0]), .ci(r_carry), .s(w_s), .co(w_co));
  // New digit enters from the top so that after NDIG shifts digit 0 sits lowest.
  if (NDIG == 1) begin : g_one
    assign w_sum_nx = w_s;
  end else begin : g_many
    assign w_sum_nx = {w_s, r_sum[4*NDIG-1:4]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_a     <= a;
          r_b     <= b;
          r_carry <= cin;
          r_err   <= |w_bad;
          r_cnt   <= '0;
          r_state <= ADD;
        end
        ADD: begin
          r_a     <= r_a >> 4;
          r_b     <= r_b >> 4;
          r_carry <= w_co;
          r_sum   <= w_sum_nx;
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == CW'(NDIG - 1)) begin
            r_cout  <= w_co;
            r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign busy = r_state != IDLE;
  assign done = r_state == DONE;
  assign sum  = r_sum;
  assign cout = r_cout;
  assign err  = r_err;
endmodule

// File: tb/tb_bcd_serial_adder.sv
// tb_bcd_serial_adder: directed vectors, expected results queued, done-driven monitor compares.
module tb_bcd_serial_adder;
  localparam int NDIG = 4;
  logic              clk = 1'b0;
  logic              rst, start, cin;
  logic [4*NDIG-1:0] a, b;
  logic              busy, done, cout, err;
  logic [4*NDIG-1:0] sum;
  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  logic [4*NDIG+1:0] exp_q[$];

  bcd_serial_adder #(.NDIG(NDIG)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) begin
      logic [4*NDIG+1:0] e;
      done_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done got sum=%h cout=%b err=%b with empty queue", sum, cout, err);
      end else begin
        e = exp_q.pop_front();
        if ({sum, cout, err} !== e) begin
          failures++;
          $display("FAIL result got sum=%h cout=%b err=%b want sum=%h cout=%b err=%b",
                   sum, cout, err, e[4*NDIG+1:2], e[1], e[0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic run_op(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                        input logic [15:0] es, input logic ec, input logic ee);
    int n;
    @(negedge clk);
    a = va; b = vb; cin = vc; start = 1'b1;
    exp_q.push_back({es, ec, ee});
    @(posedge clk); #1;
    start = 1'b0; a = '1; b = '1; cin = 1'b0;
    chk("busy_after_start", busy, 1);
    n = 1;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency_edges", n, NDIG + 1);
    @(posedge clk); #1;
    chk("idle_after_done", {busy, done}, 0);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    int n, d0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {busy, done, sum, cout, err}, 0);
    @(negedge clk); rst = 1'b0;

    run_op(16'h0999, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0);
    run_op(16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op(16'h4567, 16'h1234, 1'b1, 16'h5802, 1'b0, 1'b0);
    run_op(16'h000A, 16'h0000, 1'b0, 16'h0010, 1'b0, 1'b1);
    run_op(16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0);
    run_op(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
    run_op(16'h5000, 16'h5000, 1'b0, 16'h0000, 1'b1, 1'b0);
    chk("hold_after_done", {sum, cout, err}, {16'h0000, 1'b1, 1'b0});

    // start re-pulsed mid-operation and during DONE must be ignored
    d0 = done_cnt;
    @(negedge clk); a = 16'h1234; b = 16'h4321; cin = 1'b0; start = 1'b1;
    exp_q.push_back({16'h5555, 1'b0, 1'b0});
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(posedge clk);
    @(negedge clk); start = 1'b1; a = 16'h9999; b = 16'h9999;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    chk("repulse_done_on_time", done, 1);
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    #1;
    chk("repulse_idle", busy, 0);
    repeat (8) @(posedge clk);
    #1;
    chk("repulse_one_done", done_cnt - d0, 1);

    // reset during ADD digit 2 aborts without a done
    d0 = done_cnt;
    @(negedge clk); a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_outputs", {busy, done, sum, cout, err}, 0);
    @(negedge clk); rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt - d0, 0);

    // start held high: second op accepted in the IDLE cycle right after DONE
    @(negedge clk); a = 16'h0001; b = 16'h0002; cin = 1'b0; start = 1'b1;
    exp_q.push_back({16'h0003, 1'b0, 1'b0});
    exp_q.push_back({16'h0009, 1'b0, 1'b0});
    @(posedge clk); #1;
    a = 16'h0005; b = 16'h0004;
    wait_done(n);
    chk("b2b_first_latency", n, NDIG);
    @(posedge clk); #1;
    wait_done(n);
    chk("b2b_gap", n + 1, NDIG + 2);
    @(negedge clk); start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("b2b_stopped", busy, 0);
    chk("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
